// File: rtl/arbiter_nto1_rr_clk.sv
// Clocked N-to-1 four-phase arbiter for the NoC router output stage.
// Registers the winning packet and its source index; round-robin or fixed priority.
module arbiter_nto1_rr_clk #(
  parameter int WIDTH_packet = 57,
  parameter int NUM_IN       = 4,
  parameter int MODE         = 0,
  parameter int IDX_W        = $clog2(NUM_IN)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_IN-1:0]              in_req,
  output logic [NUM_IN-1:0]              in_ack,
  input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
  output logic                           out_req,
  input  logic                           out_ack,
  output logic [WIDTH_packet-1:0]        out_data,
  output logic [IDX_W-1:0]               out_src,
  output logic                           busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic                    out_req_reg, out_req_next;
  logic [NUM_IN-1:0]       in_ack_reg, in_ack_next;
  logic [WIDTH_packet-1:0] out_data_reg, out_data_next;
  logic [IDX_W-1:0]        out_src_reg, out_src_next;
  logic [IDX_W-1:0]        rr_ptr_reg, rr_ptr_next;
  logic                    busy_reg, busy_next;

  logic [WIDTH_packet-1:0] chan_data [NUM_IN];
  logic [NUM_IN-1:0]       below_ptr;
  logic [NUM_IN-1:0]       masked_req;
  logic [IDX_W-1:0]        win_masked, win_any, win;

  // Round-robin: requests below the pointer are masked off; if nothing remains
  // above the pointer, the search wraps to the lowest requester overall.
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH_packet +: WIDTH_packet];
      assign below_ptr[gi] = (MODE == 0) && (IDX_W'(gi) < rr_ptr_reg);
    end
  endgenerate

  assign masked_req = in_req & ~below_ptr;

  always_comb begin
    win_masked = '0;
    win_any    = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (masked_req[i]) win_masked = IDX_W'(i);
      if (in_req[i])     win_any    = IDX_W'(i);
    end
    win = (|masked_req) ? win_masked : win_any;
  end

  always_comb begin
    state_next    = state_reg;
    out_req_next  = out_req_reg;
    in_ack_next   = in_ack_reg;
    out_data_next = out_data_reg;
    out_src_next  = out_src_reg;
    rr_ptr_next   = rr_ptr_reg;
    unique case (state_reg)
      IDLE: begin
        if (|in_req) begin
          out_data_next = chan_data[win];
          out_src_next  = win;
          out_req_next  = 1'b1;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (out_ack) begin
          out_req_next              = 1'b0;
          in_ack_next               = '0;
          in_ack_next[out_src_reg]  = 1'b1;
          state_next                = RELEASE;
        end
      end
      RELEASE: begin
        // Both sides must have returned to zero before the channel is freed.
        if (!out_ack && !in_req[out_src_reg]) begin
          in_ack_next = '0;
          if (MODE == 0) begin
            rr_ptr_next = (out_src_reg == IDX_W'(NUM_IN - 1)) ? '0 : out_src_reg + IDX_W'(1);
          end
          state_next = IDLE;
        end
      end
      default: begin
        out_req_next = 1'b0;
        in_ack_next  = '0;
        state_next   = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      out_req_reg  <= 1'b0;
      in_ack_reg   <= '0;
      out_data_reg <= '0;
      out_src_reg  <= '0;
      rr_ptr_reg   <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      out_req_reg  <= out_req_next;
      in_ack_reg   <= in_ack_next;
      out_data_reg <= out_data_next;
      out_src_reg  <= out_src_next;
      rr_ptr_reg   <= rr_ptr_next;
      busy_reg     <= busy_next;
    end
  end

  assign out_req  = out_req_reg;
  assign in_ack   = in_ack_reg;
  assign out_data = out_data_reg;
  assign out_src  = out_src_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_arbiter_nto1_rr_clk.sv
// Bench for arbiter_nto1_rr_clk: a MODE=0 and a MODE=1 instance driven by a
// four-phase environment, checked every cycle against a behavioural model.
module tb_arbiter_nto1_rr_clk;
  localparam int W  = 57;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   in_req   [2];
  logic [N-1:0]   in_ack   [2];
  logic [N*W-1:0] in_data  [2];
  logic           out_req  [2];
  logic           out_ack  [2];
  logic [W-1:0]   out_data [2];
  logic [IW-1:0]  out_src  [2];
  logic           busy     [2];

  arbiter_nto1_rr_clk #(.WIDTH_packet(W), .NUM_IN(N), .MODE(0)) dut0 (
    .clk(clk), .reset(rst), .in_req(in_req[0]), .in_ack(in_ack[0]), .in_data(in_data[0]),
    .out_req(out_req[0]), .out_ack(out_ack[0]), .out_data(out_data[0]), .out_src(out_src[0]),
    .busy(busy[0]));

  arbiter_nto1_rr_clk #(.WIDTH_packet(W), .NUM_IN(N), .MODE(1)) dut1 (
    .clk(clk), .reset(rst), .in_req(in_req[1]), .in_ack(in_ack[1]), .in_data(in_data[1]),
    .out_req(out_req[1]), .out_ack(out_ack[1]), .out_data(out_data[1]), .out_src(out_src[1]),
    .busy(busy[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Environment: per-channel packet queues and a sink with programmable delays.
  int           ack_delay = 0;
  int           rel_delay = 0;
  logic [W-1:0] pq [2*N][$];
  int           scnt [2*N];
  int           kcnt [2];
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_req[d] = '0; in_data[d] = '0; out_ack[d] = 1'b0; kcnt[d] = 0;
    end
    for (int k = 0; k < 2*N; k++) scnt[k] = 0;
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < N; c++) begin
          if (rst) begin
            in_req[d][c] = 1'b0; scnt[d*N+c] = 0;
          end else if (in_req[d][c] && in_ack[d][c]) begin
            scnt[d*N+c]++;
            if (scnt[d*N+c] > rel_delay) begin
              in_req[d][c] = 1'b0;
              pq[d*N+c].delete(0);
              scnt[d*N+c] = 0;
            end
          end else if (!in_req[d][c] && !in_ack[d][c] && pq[d*N+c].size() != 0) begin
            in_req[d][c] = 1'b1;
            in_data[d][c*W +: W] = pq[d*N+c][0];
            scnt[d*N+c] = 0;
          end
        end
        if (rst) begin
          out_ack[d] = 1'b0; kcnt[d] = 0;
        end else if (out_req[d] != out_ack[d]) begin
          kcnt[d]++;
          if (kcnt[d] > ack_delay) begin
            out_ack[d] = out_req[d]; kcnt[d] = 0;
          end
        end else begin
          kcnt[d] = 0;
        end
      end
    end
  end

  // Behavioural model: phase 0 = waiting, 1 = offering packet, 2 = awaiting release.
  int           m_phase [2];
  int           m_g     [2];
  int           m_ptr   [2];
  logic         m_oreq  [2];
  logic [N-1:0] m_ack   [2];
  logic [W-1:0] m_data  [2];
  int           m_src   [2];
  logic         m_busy  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_g[d] = 0; m_ptr[d] = 0; m_oreq[d] = 1'b0;
      m_ack[d] = '0; m_data[d] = '0; m_src[d] = 0; m_busy[d] = 1'b0;
    end
  endtask

  function automatic int pick(input int d);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (d == 1) ? k : (m_ptr[d] + k) % N;
      if (in_req[d][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int d);
    int g;
    case (m_phase[d])
      0: begin
        g = pick(d);
        if (g >= 0) begin
          m_g[d] = g; m_src[d] = g; m_data[d] = in_data[d][g*W +: W];
          m_oreq[d] = 1'b1; m_busy[d] = 1'b1; m_phase[d] = 1;
        end
      end
      1: if (out_ack[d]) begin
        m_oreq[d] = 1'b0; m_ack[d][m_g[d]] = 1'b1; m_phase[d] = 2;
      end
      default: if (!out_ack[d] && !in_req[d][m_g[d]]) begin
        m_ack[d] = '0; m_busy[d] = 1'b0; m_phase[d] = 0;
        if (d == 0) m_ptr[d] = (m_g[d] + 1) % N;
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d out_req", d),  out_req[d],  m_oreq[d]);
      chk($sformatf("d%0d in_ack", d),   in_ack[d],   m_ack[d]);
      chk($sformatf("d%0d out_data", d), out_data[d], m_data[d]);
      chk($sformatf("d%0d out_src", d),  out_src[d],  m_src[d]);
      chk($sformatf("d%0d busy", d),     busy[d],     m_busy[d]);
    end
  end

  // Grant log, one line per transaction.
  logic [IW-1:0] log_src  [2][$];
  logic [W-1:0]  log_data [2][$];
  int            log_cyc  [2][$];
  logic          prev_oreq [2];
  int            ack_hi = 0;
  logic [N-1:0]  ack_or = '0;

  initial begin
    prev_oreq[0] = 1'b0; prev_oreq[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (out_req[d] && !prev_oreq[d]) begin
          log_src[d].push_back(out_src[d]);
          log_data[d].push_back(out_data[d]);
          log_cyc[d].push_back(cyc);
          $display("grant dut%0d src=%0d data=%0h cycle=%0d", d, out_src[d], out_data[d], cyc);
        end
        prev_oreq[d] = out_req[d];
      end
      if (in_ack[0] != '0) ack_hi++;
      ack_or = ack_or | in_ack[0];
    end
  end

  function automatic bit env_done(input int d);
    for (int c = 0; c < N; c++) if (pq[d*N+c].size() != 0) return 1'b0;
    return (in_req[d] == '0) && (in_ack[d] == '0) && !busy[d] && !out_ack[d] && !out_req[d];
  endfunction

  task automatic wait_done(input int d, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = env_done(d);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done dut%0d: still active after %0d cycles, expected idle", d, budget);
    end
  endtask

  task automatic clear_log(input int d);
    log_src[d].delete(); log_data[d].delete(); log_cyc[d].delete();
  endtask

  task automatic check_log(input int d, input string name, input int es[$], input logic [W-1:0] ed[$]);
    chk({name, " count"}, log_src[d].size(), es.size());
    for (int k = 0; k < es.size() && k < log_src[d].size(); k++) begin
      chk($sformatf("%s src[%0d]", name, k), log_src[d][k], es[k]);
      chk($sformatf("%s data[%0d]", name, k), log_data[d][k], ed[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           es[$];
    logic [W-1:0] ed[$];
    bit           seen;

    repeat (3) @(negedge clk);
    chk("init out_req", out_req[0], 1'b0);
    chk("init busy", busy[0], 1'b0);
    chk("init in_ack", in_ack[0], 4'b0000);
    rst = 1'b0;

    // Move the pointer to 2, then reset while a channel-2 grant is pending.
    push(0, 1, 57'h11);
    wait_done(0, 50);
    ack_delay = 5;
    push(0, 2, 57'h22);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_req[0];
    end
    chk("mid-send reached", seen, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    for (int k = 0; k < 2*N; k++) pq[k].delete();
    #1;
    chk("rst out_req", out_req[0], 1'b0);
    chk("rst in_ack", in_ack[0], 4'b0000);
    chk("rst busy", busy[0], 1'b0);
    chk("rst out_src", out_src[0], 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    clear_log(0);

    // Fairness: 25 packets per channel, data j*16+c, all requested together.
    for (int j = 0; j < 25; j++)
      for (int c = 0; c < N; c++) push(0, c, W'(j*16 + c));
    wait_done(0, 2000);
    es.delete(); ed.delete();
    for (int k = 0; k < 100; k++) begin
      es.push_back(k % 4); ed.push_back(W'((k/4)*16 + (k%4)));
    end
    check_log(0, "fair", es, ed);

    // Single channel 2.
    clear_log(0); ack_or = '0;
    push(0, 2, 57'h1A5);
    wait_done(0, 50);
    es = '{2}; ed = '{57'h1A5};
    check_log(0, "single", es, ed);
    chk("single ack pulse", ack_or, 4'b0100);

    // Pointer at 3 with channels 0 and 1 requesting, then a full round from 2.
    clear_log(0);
    push(0, 0, 57'hA0); push(0, 1, 57'hA1);
    wait_done(0, 50);
    for (int c = 0; c < N; c++) push(0, c, W'(57'hB0 + c));
    wait_done(0, 100);
    es = '{0, 1, 2, 3, 0, 1};
    ed = '{57'hA0, 57'hA1, 57'hB2, 57'hB3, 57'hB0, 57'hB1};
    check_log(0, "wrap", es, ed);

    // Slow environment on channels 2 and 3.
    clear_log(0);
    ack_delay = 5; rel_delay = 7; ack_hi = 0;
    push(0, 2, 57'hC2); push(0, 3, 57'hC3);
    wait_done(0, 200);
    es = '{2, 3}; ed = '{57'hC2, 57'hC3};
    check_log(0, "slow", es, ed);
    chk("slow in_ack cycles", ack_hi, 16);
    if (log_cyc[0].size() == 2) chk("slow grant gap", log_cyc[0][1] - log_cyc[0][0], 15);
    else chk("slow grant gap count", log_cyc[0].size(), 2);
    ack_delay = 0; rel_delay = 0;

    // Fixed priority instance: channel 1 keeps winning until it runs dry.
    clear_log(1);
    for (int j = 0; j < 5; j++) push(1, 1, W'(57'hD0 + j));
    for (int j = 0; j < 2; j++) push(1, 3, W'(57'hE0 + j));
    wait_done(1, 200);
    es = '{1, 1, 1, 1, 1, 3, 3};
    ed = '{57'hD0, 57'hD1, 57'hD2, 57'hD3, 57'hD4, 57'hE0, 57'hE1};
    check_log(1, "fixed", es, ed);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic push(input int d, input int c, input logic [W-1:0] v);
    pq[d*N+c].push_back(v);
  endtask

endmodule
